// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment scan driver with shadowed display word,
// hex glyphs, per-digit blanking and an anti-ghost gap. Optional: SEG7_LZ_SUPPRESS_EN.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 1024,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    hex_mode,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_DARK = 7'h7F;

  // Segment pattern for one nibble, {g,f,e,d,c,b,a} active-low.
  function automatic logic [6:0] f_glyph(input logic [3:0] v, input logic hex);
    logic [6:0] g;
    case (v)
      4'd0:    g = ~7'h3F;
      4'd1:    g = ~7'h06;
      4'd2:    g = ~7'h5B;
      4'd3:    g = ~7'h4F;
      4'd4:    g = ~7'h66;
      4'd5:    g = ~7'h6D;
      4'd6:    g = ~7'h7D;
      4'd7:    g = ~7'h07;
      4'd8:    g = ~7'h7F;
      4'd9:    g = ~7'h6F;
      4'd10:   g = hex ? ~7'h77 : SEG_DARK;
      4'd11:   g = hex ? ~7'h7C : SEG_DARK;
      4'd12:   g = hex ? ~7'h39 : SEG_DARK;
      4'd13:   g = hex ? ~7'h5E : SEG_DARK;
      4'd14:   g = hex ? ~7'h79 : SEG_DARK;
      default: g = hex ? ~7'h71 : SEG_DARK;
    endcase
    return g;
  endfunction

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_hex;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_slot_end;
  logic                    w_last_digit;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_suppress;
  logic [6:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;

  assign w_slot_end   = (r_cnt == CNT_MAX);
  assign w_last_digit = (r_idx == IDX_MAX);
  assign w_nib        = r_digits[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LZ_SUPPRESS_EN
  // A zero digit goes dark while every visible digit above it is also zero.
  logic [NUM_DIGITS-1:0] w_zero_above;
  always_comb begin
    w_zero_above = '0;
    w_suppress   = '0;
    w_zero_above[NUM_DIGITS-1] = 1'b1;
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_zero_above[i] = w_zero_above[i+1] &
                        (r_blank[i+1] | (r_digits[4*(i+1) +: 4] == 4'd0));
    end
    for (int i = 1; i < NUM_DIGITS; i++) begin
      w_suppress[i] = w_zero_above[i] & (r_digits[4*i +: 4] == 4'd0);
    end
  end
`else
  assign w_suppress = '0;
`endif

  // Blanked digits keep their anode asserted so every slot has equal on-time.
  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_DARK;
    if (r_cnt >= CNT_GAP) begin
      w_an_nxt[r_idx] = 1'b0;
      if (!r_blank[r_idx] && !w_suppress[r_idx]) begin
        w_seg_nxt = f_glyph(w_nib, r_hex);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digits <= '0;
      r_blank  <= '1;
      r_hex    <= 1'b0;
    end else if (load) begin
      r_digits <= digits;
      r_blank  <= blank;
      r_hex    <= hex_mode;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= w_last_digit ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_frame_done <= w_slot_end & w_last_digit;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_seg <= SEG_DARK;
      r_an  <= '1;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
